// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, keyboard command bytes
// and the frame parity helper.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_INHIBIT   = 3'd1,
      ST_SHIFT     = 3'd2,
      ST_ACK       = 3'd3,
      ST_WAIT_IDLE = 3'd4
   } ps2_tx_state_t;

   localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
   localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
   localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;

   // PS/2 frames carry odd parity: the 9 bits {parity, data} hold an odd number of ones.
   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronizes the raw PS/2 clock and data lines into the system clock domain
// and produces a registered one-cycle pulse on each falling edge of the clock line.
module ps2_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic clk_in,
   input  logic data_in,
   output logic clk_sync,
   output logic data_sync,
   output logic clk_fall
);

   logic [SYNC_STAGES-1:0] clk_chain_reg;
   logic [SYNC_STAGES-1:0] data_chain_reg;
   logic [SYNC_STAGES-1:0] clk_chain_next;
   logic [SYNC_STAGES-1:0] data_chain_next;
   logic                   clk_prev_reg;
   logic                   clk_fall_reg;

   genvar gi;
   generate
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            assign clk_chain_next[gi]  = clk_in;
            assign data_chain_next[gi] = data_in;
         end else begin : g_next
            assign clk_chain_next[gi]  = clk_chain_reg[gi-1];
            assign data_chain_next[gi] = data_chain_reg[gi-1];
         end
      end
   endgenerate

   // Chains reset to 1 (idle bus level) so no false edge appears after reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         clk_chain_reg  <= '1;
         data_chain_reg <= '1;
         clk_prev_reg   <= 1'b1;
         clk_fall_reg   <= 1'b0;
      end else begin
         clk_chain_reg  <= clk_chain_next;
         data_chain_reg <= data_chain_next;
         clk_prev_reg   <= clk_chain_reg[SYNC_STAGES-1];
         clk_fall_reg   <= clk_prev_reg & ~clk_chain_reg[SYNC_STAGES-1];
      end
   end

   assign clk_sync  = clk_chain_reg[SYNC_STAGES-1];
   assign data_sync = data_chain_reg[SYNC_STAGES-1];
   assign clk_fall  = clk_fall_reg;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter driving open-collector enables.
// Define PS2_TX_TIMEOUT_EN to add the per-frame watchdog.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 10000,
   parameter int TIMEOUT_CYCLES = 2000000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       tx_done,
   output logic       tx_ack_err,
   output logic       tx_timeout
);

   localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
   localparam logic [INH_W-1:0] INH_LAST  = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [INH_W-1:0] INH_START = INH_W'(INHIBIT_CYCLES - 2);

   ps2_tx_state_t    state_reg;
   logic [8:0]       shift_reg;
   logic [3:0]       bitcnt_reg;
   logic [INH_W-1:0] inh_cnt_reg;
   logic             nack_reg;
   logic             clk_oe_reg;
   logic             data_oe_reg;
   logic             tx_ready_reg;
   logic             busy_reg;
   logic             tx_done_reg;
   logic             tx_ack_err_reg;
   logic             tx_timeout_reg;

   logic clk_sync;
   logic data_sync;
   logic clk_fall;
   logic wd_fire;

   ps2_line_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_line_sync (
      .clock     (clock),
      .reset     (reset),
      .clk_in    (ps2_clk_in),
      .data_in   (ps2_data_in),
      .clk_sync  (clk_sync),
      .data_sync (data_sync),
      .clk_fall  (clk_fall)
   );

`ifdef PS2_TX_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   logic [WD_W-1:0] wd_cnt_reg;

   // Held at zero in IDLE, so counting starts on the accept cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wd_cnt_reg <= '0;
      end else if (state_reg == ST_IDLE || wd_fire) begin
         wd_cnt_reg <= '0;
      end else begin
         wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
      end
   end

   assign wd_fire = (state_reg != ST_IDLE) && (wd_cnt_reg == WD_LAST);
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign wd_fire            = 1'b0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         shift_reg      <= '0;
         bitcnt_reg     <= '0;
         inh_cnt_reg    <= '0;
         nack_reg       <= 1'b0;
         clk_oe_reg     <= 1'b0;
         data_oe_reg    <= 1'b0;
         tx_ready_reg   <= 1'b1;
         busy_reg       <= 1'b0;
         tx_done_reg    <= 1'b0;
         tx_ack_err_reg <= 1'b0;
         tx_timeout_reg <= 1'b0;
      end else begin
         tx_done_reg    <= 1'b0;
         tx_ack_err_reg <= 1'b0;
         tx_timeout_reg <= 1'b0;
         if (wd_fire) begin
            tx_timeout_reg <= 1'b1;
            tx_done_reg    <= 1'b1;
            tx_ack_err_reg <= 1'b1;
            clk_oe_reg     <= 1'b0;
            data_oe_reg    <= 1'b0;
            tx_ready_reg   <= 1'b1;
            busy_reg       <= 1'b0;
            state_reg      <= ST_IDLE;
         end else begin
            case (state_reg)
               ST_IDLE: begin
                  if (tx_valid && tx_ready_reg) begin
                     shift_reg    <= {odd_parity(tx_data), tx_data};
                     inh_cnt_reg  <= '0;
                     bitcnt_reg   <= '0;
                     nack_reg     <= 1'b0;
                     clk_oe_reg   <= 1'b1;
                     tx_ready_reg <= 1'b0;
                     busy_reg     <= 1'b1;
                     state_reg    <= ST_INHIBIT;
                  end
               end
               ST_INHIBIT: begin
                  // Start bit is asserted in the last inhibit cycle, before the clock is released.
                  if (inh_cnt_reg == INH_LAST) begin
                     clk_oe_reg <= 1'b0;
                     bitcnt_reg <= '0;
                     state_reg  <= ST_SHIFT;
                  end else begin
                     inh_cnt_reg <= inh_cnt_reg + INH_W'(1);
                     if (inh_cnt_reg == INH_START) begin
                        data_oe_reg <= 1'b1;
                     end
                  end
               end
               ST_SHIFT: begin
                  if (clk_fall) begin
                     if (bitcnt_reg < 4'd9) begin
                        data_oe_reg <= ~shift_reg[0];
                        shift_reg   <= {1'b0, shift_reg[8:1]};
                        bitcnt_reg  <= bitcnt_reg + 4'd1;
                     end else begin
                        data_oe_reg <= 1'b0;
                        bitcnt_reg  <= 4'd10;
                        state_reg   <= ST_ACK;
                     end
                  end
               end
               ST_ACK: begin
                  if (clk_fall) begin
                     nack_reg  <= data_sync;
                     state_reg <= ST_WAIT_IDLE;
                  end
               end
               ST_WAIT_IDLE: begin
                  // tx_done is raised while still busy; IDLE follows one cycle later.
                  if (tx_done_reg) begin
                     tx_ready_reg <= 1'b1;
                     busy_reg     <= 1'b0;
                     state_reg    <= ST_IDLE;
                  end else if (clk_sync && data_sync) begin
                     tx_done_reg    <= 1'b1;
                     tx_ack_err_reg <= nack_reg;
                  end
               end
               default: begin
                  clk_oe_reg   <= 1'b0;
                  data_oe_reg  <= 1'b0;
                  tx_ready_reg <= 1'b1;
                  busy_reg     <= 1'b0;
                  state_reg    <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign tx_ready    = tx_ready_reg;
   assign busy        = busy_reg;
   assign ps2_clk_oe  = clk_oe_reg;
   assign ps2_data_oe = data_oe_reg;
   assign tx_done     = tx_done_reg;
   assign tx_ack_err  = tx_ack_err_reg;
   assign tx_timeout  = tx_timeout_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on wired-AND lines.
// Builds with or without PS2_TX_TIMEOUT_EN; the watchdog scenario adapts.
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int INH  = 100;
   localparam int TMO  = 3000;
   localparam int HALF = 20;

   logic       clock;
   logic       reset;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       ps2_clk_in;
   logic       ps2_data_in;
   logic       ps2_clk_oe;
   logic       ps2_data_oe;
   logic       busy;
   logic       tx_done;
   logic       tx_ack_err;
   logic       tx_timeout;

   logic dev_clk_low;
   logic dev_data_low;

   int checks;
   int errors;
   int accept_cnt;
   bit timeout_seen;

   ps2_host_tx #(
      .INHIBIT_CYCLES (INH),
      .TIMEOUT_CYCLES (TMO),
      .SYNC_STAGES    (2)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_data_in (ps2_data_in),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe),
      .busy        (busy),
      .tx_done     (tx_done),
      .tx_ack_err  (tx_ack_err),
      .tx_timeout  (tx_timeout)
   );

   // Open-collector lines with pull-ups.
   assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (!reset && tx_valid && tx_ready) accept_cnt++;
   end

   always @(negedge clock) begin
      if (tx_timeout === 1'b1) timeout_seen = 1'b1;
   end

   initial begin
      #5000000;
      $display("FAIL sim_watchdog: simulation did not finish, required completion");
      $fatal(1, "simulation time limit");
   end

   task automatic start_frame(input logic [7:0] d);
      @(negedge clock);
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clock);
      tx_valid = 1'b0;
   endtask

   // Device side: records {stop, parity, d7..d0, start}, then optionally acks.
   task automatic device_frame(input bit do_ack, input int abort_at, input bit mutate,
                               output logic [10:0] bits, output bit ok);
      ok   = 1'b0;
      bits = 'x;
      for (int i = 0; i < 2000 && !ok; i++) begin
         @(negedge clock);
         if (ps2_clk_in === 1'b1 && ps2_data_in === 1'b0) ok = 1'b1;
      end
      if (!ok) return;
      bits[0] = ps2_data_in;
      repeat (HALF) @(negedge clock);
      for (int k = 1; k <= 11; k++) begin
         dev_clk_low = 1'b1;
         if (mutate && k == 3) tx_data = 8'h3C;
         repeat (HALF) @(negedge clock);
         if (k == abort_at) begin
            dev_clk_low = 1'b0;
            return;
         end
         dev_clk_low = 1'b0;
         if (k <= 10) bits[k] = ps2_data_in;
         if (k == 10 && do_ack) dev_data_low = 1'b1;
         if (k == 11) dev_data_low = 1'b0;
         if (k < 11) repeat (HALF) @(negedge clock);
      end
   endtask

   task automatic wait_done(output bit seen, output logic ack_err,
                            output logic rdy_during, output logic rdy_after);
      seen       = 1'b0;
      ack_err    = 1'bx;
      rdy_during = 1'bx;
      rdy_after  = 1'bx;
      for (int i = 0; i < 500 && !seen; i++) begin
         @(negedge clock);
         if (tx_done === 1'b1) begin
            seen       = 1'b1;
            ack_err    = tx_ack_err;
            rdy_during = tx_ready;
         end
      end
      if (seen) begin
         @(negedge clock);
         rdy_after = tx_ready;
      end
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      tx_valid = 1'b1;
      tx_data  = 8'h55;
      repeat (3) @(negedge clock);
      checks++; if (ps2_clk_oe !== 1'b0) begin errors++; $display("FAIL reset_clk_oe got %b want 0", ps2_clk_oe); end
      checks++; if (ps2_data_oe !== 1'b0) begin errors++; $display("FAIL reset_data_oe got %b want 0", ps2_data_oe); end
      checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready got %b want 1", tx_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if ({tx_done, tx_ack_err, tx_timeout} !== 3'b000) begin
         errors++; $display("FAIL reset_pulses got %b want 000", {tx_done, tx_ack_err, tx_timeout});
      end
      tx_valid = 1'b0;
      reset    = 1'b0;
      repeat (2) @(negedge clock);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_no_accept busy got %b want 0", busy); end
      $display("reset: oe=%b%b ready=%b busy=%b", ps2_clk_oe, ps2_data_oe, tx_ready, busy);
   endtask

   task automatic test_set_led();
      logic [10:0] bits;
      bit ok, seen;
      logic ack_err, rd, ra, data_last, early;
      int n;
      start_frame(PS2_CMD_SET_LED);
      checks++; if (busy !== 1'b1 || tx_ready !== 1'b0) begin
         errors++; $display("FAIL accept_flags busy/ready got %b%b want 10", busy, tx_ready);
      end
      n = 0; data_last = 1'b0; early = 1'b0;
      while (ps2_clk_oe === 1'b1 && n < 1000) begin
         early     = early | data_last;
         data_last = ps2_data_oe;
         n++;
         @(negedge clock);
      end
      checks++; if (n != INH) begin errors++; $display("FAIL inhibit_len got %0d want %0d", n, INH); end
      checks++; if (early !== 1'b0 || data_last !== 1'b1) begin
         errors++; $display("FAIL start_bit_timing early=%b last=%b want 0 1", early, data_last);
      end
      device_frame(1'b1, 0, 1'b0, bits, ok);
      checks++; if (!ok || bits !== {1'b1, 1'b1, 8'hED, 1'b0}) begin
         errors++; $display("FAIL wire_0xED got %b want %b", bits, {1'b1, 1'b1, 8'hED, 1'b0});
      end
      wait_done(seen, ack_err, rd, ra);
      checks++; if (!seen || ack_err !== 1'b0) begin errors++; $display("FAIL done_ack_0xED seen=%b ack_err=%b want 1 0", seen, ack_err); end
      checks++; if (rd !== 1'b0 || ra !== 1'b1) begin
         errors++; $display("FAIL ready_after_done during=%b after=%b want 0 1", rd, ra);
      end
      $display("frame 0xED: inhibit=%0d wire=%b ack_err=%b", n, bits, ack_err);
   endtask

   task automatic test_parity();
      logic [7:0] vec  [3] = '{8'h00, 8'hFF, 8'h01};
      logic       par  [3] = '{1'b1, 1'b1, 1'b0};
      logic [10:0] bits;
      bit ok, seen;
      logic ack_err, rd, ra;
      for (int i = 0; i < 3; i++) begin
         start_frame(vec[i]);
         device_frame(1'b1, 0, 1'b0, bits, ok);
         checks++; if (!ok || bits[9] !== par[i]) begin
            errors++; $display("FAIL parity_%02h got %b want %b", vec[i], bits[9], par[i]);
         end
         checks++; if (bits[8:1] !== vec[i] || bits[10] !== 1'b1 || bits[0] !== 1'b0) begin
            errors++; $display("FAIL frame_%02h got %b", vec[i], bits);
         end
         wait_done(seen, ack_err, rd, ra);
         checks++; if (!seen || ack_err !== 1'b0) begin
            errors++; $display("FAIL done_%02h seen=%b ack_err=%b want 1 0", vec[i], seen, ack_err);
         end
         $display("frame 0x%02h: wire=%b ack_err=%b", vec[i], bits, ack_err);
      end
   endtask

   task automatic test_no_ack();
      logic [10:0] bits;
      bit ok, seen;
      logic ack_err, rd, ra;
      start_frame(PS2_CMD_RESET);
      device_frame(1'b0, 0, 1'b0, bits, ok);
      wait_done(seen, ack_err, rd, ra);
      checks++; if (!seen || ack_err !== 1'b1) begin errors++; $display("FAIL no_ack seen=%b ack_err=%b want 1 1", seen, ack_err); end
      checks++; if (ra !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL no_ack_idle ready=%b busy=%b want 1 0", ra, busy); end
      $display("frame 0xFF no-ack: wire=%b ack_err=%b", bits, ack_err);
   endtask

   task automatic test_reset_mid_shift();
      logic [10:0] bits;
      bit ok, seen;
      logic ack_err, rd, ra;
      start_frame(8'h00);
      device_frame(1'b1, 5, 1'b0, bits, ok);
      checks++; if (ps2_data_oe !== 1'b1) begin errors++; $display("FAIL mid_shift_data_oe got %b want 1", ps2_data_oe); end
      reset = 1'b1;
      #1;
      checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
         errors++; $display("FAIL async_release oe=%b%b want 00", ps2_clk_oe, ps2_data_oe);
      end
      checks++; if (tx_ready !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL async_ready ready=%b busy=%b want 1 0", tx_ready, busy);
      end
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      start_frame(PS2_CMD_RESET);
      device_frame(1'b1, 0, 1'b0, bits, ok);
      wait_done(seen, ack_err, rd, ra);
      checks++; if (!ok || bits !== {1'b1, 1'b1, 8'hFF, 1'b0} || !seen || ack_err !== 1'b0) begin
         errors++; $display("FAIL post_reset_0xFF wire=%b seen=%b ack_err=%b", bits, seen, ack_err);
      end
      $display("frame 0xFF after reset: wire=%b ack_err=%b", bits, ack_err);
   endtask

   task automatic test_back_to_back();
      logic [10:0] bits;
      bit ok, seen;
      logic ack_err, rd, ra;
      int a0;
      @(negedge clock);
      a0       = accept_cnt;
      tx_data  = 8'hA5;
      tx_valid = 1'b1;
      device_frame(1'b1, 0, 1'b1, bits, ok);
      wait_done(seen, ack_err, rd, ra);
      checks++; if (!ok || bits[8:1] !== 8'hA5) begin errors++; $display("FAIL latched_byte got %02h want a5", bits[8:1]); end
      checks++; if (accept_cnt - a0 != 1 || !seen) begin
         errors++; $display("FAIL single_accept got %0d want 1 seen=%b", accept_cnt - a0, seen);
      end
      @(negedge clock);
      checks++; if (accept_cnt - a0 != 2 || ps2_clk_oe !== 1'b1) begin
         errors++; $display("FAIL next_accept got %0d clk_oe=%b want 2 1", accept_cnt - a0, ps2_clk_oe);
      end
      tx_valid = 1'b0;
      device_frame(1'b1, 0, 1'b0, bits, ok);
      wait_done(seen, ack_err, rd, ra);
      checks++; if (!ok || bits[8:1] !== 8'h3C || !seen || ack_err !== 1'b0) begin
         errors++; $display("FAIL second_frame got %02h seen=%b ack_err=%b want 3c 1 0", bits[8:1], seen, ack_err);
      end
      $display("back-to-back: accepts=%0d second=%02h", accept_cnt - a0, bits[8:1]);
   endtask

   task automatic test_watchdog();
      checks++; if (timeout_seen !== 1'b0) begin errors++; $display("FAIL spurious_timeout got 1 want 0"); end
      start_frame(8'h12);
`ifdef PS2_TX_TIMEOUT_EN
      begin
         int k;
         k = 0;
         for (int i = 1; i <= TMO + 50 && k == 0; i++) begin
            @(negedge clock);
            if (tx_timeout === 1'b1) begin
               k = i;
               checks++; if (tx_done !== 1'b1 || tx_ack_err !== 1'b1) begin
                  errors++; $display("FAIL timeout_pulses done=%b ack_err=%b want 1 1", tx_done, tx_ack_err);
               end
               checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
                  errors++; $display("FAIL timeout_release oe=%b%b want 00", ps2_clk_oe, ps2_data_oe);
               end
            end
         end
         checks++; if (k != TMO) begin errors++; $display("FAIL timeout_cycle got %0d want %0d", k, TMO); end
         $display("watchdog: fired after %0d cycles", k);
      end
`else
      repeat (800) @(negedge clock);
      checks++; if (busy !== 1'b1 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b1) begin
         errors++; $display("FAIL hang_in_shift busy=%b oe=%b%b want 1 01", busy, ps2_clk_oe, ps2_data_oe);
      end
      checks++; if (timeout_seen !== 1'b0) begin errors++; $display("FAIL timeout_disabled got 1 want 0"); end
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      $display("no device: hung busy=%b until reset", busy);
`endif
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      accept_cnt   = 0;
      timeout_seen = 1'b0;
      reset        = 1'b1;
      tx_valid     = 1'b0;
      tx_data      = 8'h00;
      dev_clk_low  = 1'b0;
      dev_data_low = 1'b0;
      test_reset();
      test_set_led();
      test_parity();
      test_no_ack();
      test_reset_mid_shift();
      test_back_to_back();
      test_watchdog();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
